instr_fetch_buffer: RTL and testbench
=====================================

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 The module SHALL have parameter I_ADDR_W, default 6, meaning the byte-address width of the instruction bus.
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning the number of buffered instructions (power of two, >=2).
REQ-003 The module SHALL have port clk, input, 1 bit, meaning the clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit, meaning the reset, asynchronous, active-low.
REQ-005 The module SHALL have port redirect, input, 1 bit, meaning a taken branch/jump that discards the buffer and restarts fetch.
REQ-006 The module SHALL have port redirect_pc, input, I_ADDR_W bits, meaning the new fetch address, valid when redirect=1.
REQ-007 The module SHALL have port imem_req, output, 1 bit, meaning an instruction-memory read request.
REQ-008 The module SHALL have port imem_addr, output, I_ADDR_W bits, meaning the request address.
REQ-009 The module SHALL have port imem_ack, input, 1 bit, meaning imem_rdata is valid for the current request.
REQ-010 The module SHALL have port imem_rdata, input, 32 bits, meaning the fetched instruction word.
REQ-011 The module SHALL have ports inst_valid (output, 1), inst_ready (input, 1), inst_data (output, 32) and inst_pc (output, I_ADDR_W), meaning the valid/ready instruction stream to the datapath.
REQ-012 The module SHALL have port fifo_count, output, clog2(DEPTH)+1 bits, meaning the number of buffered entries.

Function
REQ-013 fetch_pc SHALL be a register that increments by 4 modulo 2^I_ADDR_W on every accepted fetch, wrapping from the top address to 0.
REQ-014 The FSM SHALL have exactly three states: IDLE (imem_req=0), WAIT (imem_req=1, imem_addr=fetch_pc), and DRAIN (imem_req=1, stale address held).
REQ-015 The FSM SHALL transition IDLE->WAIT when count+outstanding<DEPTH and redirect=0.
REQ-016 In WAIT, with imem_ack=1 and redirect=0, the FSM SHALL push {imem_rdata, imem_addr}, advance fetch_pc, and stay in WAIT if a slot remains after the push, else go to IDLE.
REQ-017 imem_addr SHALL remain stable while imem_req=1 and imem_ack=0.
REQ-018 At most one request SHALL be outstanding, and issue SHALL reserve a FIFO slot so that a push never finds the FIFO full.
REQ-019 inst_valid SHALL equal (count!=0); inst_data and inst_pc SHALL show the oldest entry; a pop SHALL occur when inst_valid and inst_ready are both 1.
REQ-020 A push and a pop in the same cycle SHALL leave count unchanged, and head and tail SHALL wrap modulo DEPTH.
REQ-021 On redirect=1, the module SHALL set count to 0 and fetch_pc to redirect_pc; a pop in the same cycle SHALL be ignored.
REQ-022 On redirect in WAIT with imem_ack=0, the FSM SHALL go to DRAIN, keeping imem_req and the old imem_addr until ack, discarding that data, and then going to WAIT at the new fetch_pc.
REQ-023 On redirect in WAIT with imem_ack=1 in the same cycle, the acked data SHALL be discarded and the FSM SHALL go to WAIT at redirect_pc.
REQ-024 On redirect in DRAIN, the module SHALL update fetch_pc only; the most recent redirect_pc wins.
REQ-025 Latency SHALL be: with imem_ack tied to 1, the first imem_req occurs 1 cycle after reset release, inst_valid occurs 2 cycles after it, and sustained throughput is 1 instruction per cycle.

Reset
REQ-026 While reset=0, asynchronously: state=IDLE, fetch_pc=0, count=0, head=tail=0, imem_req=0, imem_addr=0, inst_valid=0, fifo_count=0; inst_data and inst_pc SHALL be 0.
REQ-027 Reset asserted mid-request SHALL abandon the request without draining, and the memory SHALL tolerate a dropped request.
REQ-028 The FIFO storage array SHALL not require reset.

Structure
REQ-029 The state encoding (IDLE/WAIT/DRAIN), the default DEPTH and I_ADDR_W, and the PC increment constant 4 SHALL live in the shared package ifb_pkg.
REQ-030 Storage and pointers SHALL be one sub-module, ifb_fifo (push, pop, flush, count), and the FSM and fetch_pc SHALL stay in the top level.

Verification
REQ-031 Scenario: imem_ack=1, inst_ready=1 after reset -> inst_pc sequence 0,4,8,... one per cycle, wrapping 60->0.
REQ-032 Scenario: inst_ready=0, ack=1 -> exactly 4 pushes (pc 0..12), fifo_count=4, imem_req=0; then inst_ready=1 -> fetch resumes at 16.
REQ-033 Scenario: ack delayed 3 cycles -> imem_addr held at 8 for all 3 cycles, and one push of pc 8.
REQ-034 Scenario: redirect to 0x20 while waiting on addr 8 (ack 2 cycles later) -> the word for 8 is discarded, the next request goes to 0x20, and the first inst_pc is 0x20.
REQ-035 Scenario: redirect to 0x10 same cycle as ack and pop with count=2 -> count becomes 0, no push, and the next imem_addr is 0x10.
REQ-036 Scenario: reset pulsed low mid-WAIT with count=3 -> outputs immediately reach their reset values, and after release fetch restarts at 0.

Source files
------------

// File: rtl/ifb_pkg.sv
// Shared constants for the instruction fetch buffer.
//   ST_IDLE / ST_WAIT / ST_DRAIN : fetch FSM state encoding
//   DEF_I_ADDR_W, DEF_DEPTH      : default instruction byte-address width and buffer depth
//   PC_INC                       : fetch address step (one 32-bit word)
//   INST_W                       : instruction word width
package ifb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;  // no request on the bus
  localparam logic [1:0] ST_WAIT  = 2'd1;  // request at fetch_pc, data will be kept
  localparam logic [1:0] ST_DRAIN = 2'd2;  // stale request in flight, data will be dropped

  localparam int DEF_I_ADDR_W = 6;
  localparam int DEF_DEPTH    = 4;
  localparam int PC_INC       = 4;
  localparam int INST_W       = 32;

endpackage

// File: rtl/instr_fetch_buffer_if.sv
// Bus bundle of the instruction fetch buffer.
//   imem_req/imem_addr/imem_ack/imem_rdata : instruction-memory read channel
//   inst_valid/inst_ready/inst_data/inst_pc : valid/ready instruction stream to the datapath
// master = fetch buffer side, slave = memory + datapath side.
interface instr_fetch_buffer_if
  import ifb_pkg::*;
#(
  parameter int I_ADDR_W = DEF_I_ADDR_W
);

  logic                imem_req;
  logic [I_ADDR_W-1:0] imem_addr;
  logic                imem_ack;
  logic [INST_W-1:0]   imem_rdata;

  logic                inst_valid;
  logic                inst_ready;
  logic [INST_W-1:0]   inst_data;
  logic [I_ADDR_W-1:0] inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_ack, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_ack, imem_rdata, inst_ready
  );

endinterface

// File: rtl/ifb_fifo.sv
// Circular buffer holding fetched {instruction, pc} entries.
//   push/wdata : append an entry (ignored when full or flushing)
//   pop        : drop the oldest entry (ignored when empty or flushing)
//   flush      : empty the buffer, takes priority over push/pop
//   rdata      : oldest entry, forced to 0 while empty
//   count      : number of valid entries, 0..DEPTH
module ifb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 38
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_push = push && !flush && (count_q != CW'(DEPTH));
    do_pop  = pop  && !flush && (count_q != '0);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pointers are PW bits wide and DEPTH is a power of two, so +1 wraps modulo DEPTH.
      if (do_push) tail_d = tail_q + 1'b1;
      if (do_pop)  head_d = head_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array has no reset; an entry is never observed before it is written because rdata is gated by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail_q] <= wdata;
  end

  assign rdata = (count_q != '0) ? mem[head_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: issues one instruction-memory read at a time,
// buffers returned words with their pc, and streams them to the datapath.
//   clk, reset       : clock, asynchronous active-low reset
//   redirect(_pc)    : taken branch/jump; discards buffered words and restarts fetch
//   bus (master)     : imem request channel and inst valid/ready stream
//   fifo_count       : number of buffered entries
// A request is only issued while a buffer slot is free for its data, so a push
// never meets a full buffer. A redirect while a request is in flight without an
// ack parks the old address in DRAIN until the memory answers, then drops that word.
module instr_fetch_buffer
  import ifb_pkg::*;
#(
  parameter int I_ADDR_W = DEF_I_ADDR_W,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect,
  input  logic [I_ADDR_W-1:0]     redirect_pc,
  instr_fetch_buffer_if.master    bus,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W  = INST_W + I_ADDR_W;

  logic [1:0]          state_q, state_d;
  logic [I_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [I_ADDR_W-1:0] drain_addr_q, drain_addr_d;
  logic                push, pop;
  logic [CW-1:0]       count;
  logic [W-1:0]        fifo_rdata;

  assign pop = (count != '0) && bus.inst_ready;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    push         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Nothing outstanding here, so a free slot is simply count < DEPTH.
        if (redirect)                 fetch_pc_d = redirect_pc;
        else if (count < CW'(DEPTH))  state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          if (!bus.imem_ack) begin
            state_d      = ST_DRAIN;
            drain_addr_d = fetch_pc_q;
          end
        end else if (bus.imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + I_ADDR_W'(PC_INC);
          // The push fills the last slot unless a pop frees one in the same cycle.
          if (!pop && count == CW'(DEPTH - 1)) state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (redirect)     fetch_pc_d = redirect_pc;
        if (bus.imem_ack) state_d    = ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= '0;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  ifb_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({bus.imem_rdata, fetch_pc_q}),
    .rdata (fifo_rdata),
    .count (count)
  );

  assign bus.imem_req   = (state_q != ST_IDLE);
  assign bus.imem_addr  = (state_q == ST_DRAIN) ? drain_addr_q : fetch_pc_q;
  assign bus.inst_valid = (count != '0);
  assign bus.inst_data  = fifo_rdata[W-1:I_ADDR_W];
  assign bus.inst_pc    = fifo_rdata[I_ADDR_W-1:0];
  assign fifo_count     = count;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: directed table, hand-written
// corner sequences, and a randomized run against a queue-based reference model.
module tb_instr_fetch_buffer;

  localparam int AW    = 6;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [2:0]    fifo_count;

  instr_fetch_buffer_if #(.I_ADDR_W(AW)) bus ();

  instr_fetch_buffer #(
    .I_ADDR_W (AW),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [31:0] word_of(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input bit e_req, input logic [AW-1:0] e_addr,
                           input bit e_valid, input logic [AW-1:0] e_pc, input int e_cnt);
    check({tag, ".req"}, 64'(bus.imem_req), 64'(e_req));
    if (e_req) check({tag, ".addr"}, 64'(bus.imem_addr), 64'(e_addr));
    check({tag, ".valid"}, 64'(bus.inst_valid), 64'(e_valid));
    check({tag, ".count"}, 64'(fifo_count), 64'(e_cnt));
    if (e_valid) begin
      check({tag, ".pc"}, 64'(bus.inst_pc), 64'(e_pc));
      check({tag, ".data"}, 64'(bus.inst_data), 64'(word_of(e_pc)));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".req"},   64'(bus.imem_req),   64'd0);
    check({tag, ".addr"},  64'(bus.imem_addr),  64'd0);
    check({tag, ".valid"}, 64'(bus.inst_valid), 64'd0);
    check({tag, ".count"}, 64'(fifo_count),     64'd0);
    check({tag, ".data"},  64'(bus.inst_data),  64'd0);
    check({tag, ".pc"},    64'(bus.inst_pc),    64'd0);
  endtask

  // Hold reset across one rising edge, check the reset state, release #1 after the edge.
  task automatic do_reset();
    reset          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    bus.imem_ack   = 1'b0;
    bus.inst_ready = 1'b0;
    bus.imem_rdata = '0;
    @(posedge clk); #1;
    check_zero("reset");
    reset = 1'b1;
  endtask

  // One clock: drive inputs, let the memory answer with word_of(addr), sample #1 after the edge.
  task automatic step(input bit ack, input bit rdy, input bit redir, input logic [AW-1:0] rpc);
    bus.imem_ack   = ack;
    bus.inst_ready = rdy;
    redirect       = redir;
    redirect_pc    = rpc;
    bus.imem_rdata = word_of(bus.imem_addr);
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  typedef struct {
    bit            ack;
    bit            rdy;
    bit            e_req;
    logic [AW-1:0] e_addr;
    bit            e_valid;
    logic [AW-1:0] e_pc;
    int            e_cnt;
  } vec_t;

  vec_t tbl [10];

  typedef struct packed {
    logic [31:0]   data;
    logic [AW-1:0] pc;
  } ent_t;

  // Reference model: queue of buffered words, next fetch pc, whether a request
  // is in flight, and whether that in-flight request was overtaken by a redirect.
  ent_t          mq [$];
  logic [AW-1:0] m_fpc, m_stale_addr;
  bit            m_busy, m_stale;

  initial begin
    // Back-pressure: four words fill the buffer, fetch stops, then resumes at 16.
    tbl[0] = '{1'b1, 1'b0, 1'b1, 6'd0,  1'b0, 6'd0,  0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 6'd4,  1'b1, 6'd0,  1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 6'd8,  1'b1, 6'd0,  2};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 6'd12, 1'b1, 6'd0,  3};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 6'd16, 1'b1, 6'd0,  4};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 6'd16, 1'b1, 6'd0,  4};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 6'd16, 1'b1, 6'd4,  3};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 6'd16, 1'b1, 6'd8,  2};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 6'd20, 1'b1, 6'd12, 2};
    tbl[9] = '{1'b1, 1'b1, 1'b1, 6'd24, 1'b1, 6'd16, 2};

    // Streaming with ack and ready tied high: one word per cycle, pc wraps 60 -> 0.
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      if (n == 1) check_out("stream_first", 1'b1, 6'd0, 1'b0, 6'd0, 0);
      else        check_out("stream", 1'b1, AW'(4 * (n - 1)), 1'b1, AW'(4 * (n - 2)), 1);
    end

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].ack, tbl[i].rdy, 1'b0, '0);
      check_out($sformatf("tbl%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
                tbl[i].e_pc, tbl[i].e_cnt);
    end

    // Ack delayed three cycles: address held at 8, then exactly one push of pc 8.
    do_reset();
    repeat (3) step(1'b1, 1'b1, 1'b0, '0);
    check_out("dly_pre", 1'b1, 6'd8, 1'b1, 6'd4, 1);
    repeat (3) begin
      step(1'b0, 1'b1, 1'b0, '0);
      check_out("dly_hold", 1'b1, 6'd8, 1'b0, 6'd0, 0);
    end
    step(1'b1, 1'b1, 1'b0, '0);
    check_out("dly_push", 1'b1, 6'd12, 1'b1, 6'd8, 1);

    // Redirect to 0x20 while waiting on address 8; the word for 8 arrives later and is dropped.
    do_reset();
    repeat (3) step(1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 6'h20);
    check_out("drain0", 1'b1, 6'd8, 1'b0, 6'd0, 0);
    step(1'b0, 1'b1, 1'b0, '0);
    check_out("drain1", 1'b1, 6'd8, 1'b0, 6'd0, 0);
    step(1'b1, 1'b1, 1'b0, '0);
    check_out("drain_ack", 1'b1, 6'h20, 1'b0, 6'd0, 0);
    step(1'b1, 1'b1, 1'b0, '0);
    check_out("drain_new", 1'b1, 6'h24, 1'b1, 6'h20, 1);

    // Redirect coincident with ack and pop while two words are buffered.
    do_reset();
    repeat (3) step(1'b1, 1'b0, 1'b0, '0);
    check_out("rdack_pre", 1'b1, 6'd8, 1'b1, 6'd0, 2);
    step(1'b1, 1'b1, 1'b1, 6'h10);
    check_out("rdack", 1'b1, 6'h10, 1'b0, 6'd0, 0);
    step(1'b1, 1'b0, 1'b0, '0);
    check_out("rdack_post", 1'b1, 6'h14, 1'b1, 6'h10, 1);

    // Reset pulsed mid-request with three words buffered: outputs clear without a clock edge.
    do_reset();
    repeat (4) step(1'b1, 1'b0, 1'b0, '0);
    check_out("mid_pre", 1'b1, 6'd12, 1'b1, 6'd0, 3);
    bus.imem_ack = 1'b0;
    #2 reset = 1'b0;
    #1 check_zero("mid_async");
    @(posedge clk); #1;
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0, '0);
    check_out("mid_restart0", 1'b1, 6'd0, 1'b0, 6'd0, 0);
    step(1'b1, 1'b1, 1'b0, '0);
    check_out("mid_restart1", 1'b1, 6'd4, 1'b1, 6'd0, 1);

    // Randomized traffic against the reference model.
    do_reset();
    mq.delete();
    m_fpc   = '0;
    m_stale_addr = '0;
    m_busy  = 1'b0;
    m_stale = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bit            a, r, rd;
      logic [31:0]   rnd, d;
      logic [AW-1:0] rpc;
      int            old_size;
      a   = ($urandom_range(0, 9) < 7);
      r   = ($urandom_range(0, 9) < 6);
      rd  = ($urandom_range(0, 19) == 0);
      rnd = $urandom;
      rpc = {rnd[AW-1:2], 2'b00};
      d   = $urandom;
      bus.imem_ack   = a;
      bus.inst_ready = r;
      redirect       = rd;
      redirect_pc    = rpc;
      bus.imem_rdata = d;

      old_size = mq.size();
      if (rd) begin
        mq.delete();
        if (m_busy) begin
          if (a) m_stale = 1'b0;
          else if (!m_stale) begin
            m_stale      = 1'b1;
            m_stale_addr = m_fpc;
          end
        end
        m_fpc = rpc;
      end else begin
        if (old_size != 0 && r) void'(mq.pop_front());
        if (m_busy && a) begin
          if (!m_stale) begin
            mq.push_back('{d, m_fpc});
            m_fpc = m_fpc + AW'(4);
          end
          m_stale = 1'b0;
          m_busy  = (mq.size() < DEPTH);
        end else if (!m_busy) begin
          m_busy = (old_size < DEPTH);
        end
      end

      @(posedge clk); #1;
      redirect = 1'b0;

      check("rnd.req", 64'(bus.imem_req), 64'(m_busy));
      if (m_busy) check("rnd.addr", 64'(bus.imem_addr), 64'(m_stale ? m_stale_addr : m_fpc));
      check("rnd.valid", 64'(bus.inst_valid), 64'(mq.size() != 0));
      check("rnd.count", 64'(fifo_count), 64'(mq.size()));
      if (mq.size() != 0) begin
        check("rnd.pc",   64'(bus.inst_pc),   64'(mq[0].pc));
        check("rnd.data", 64'(bus.inst_data), 64'(mq[0].data));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
